circle_engine: RTL
==================

Name: circle_engine

Overview:
- Parametrised successor to the fixed 160x120 Bresenham circle drawer used after the black-screen fill.
- Draws a circle centred at (centre_x, centre_y) with a given radius and colour, emitting one pixel per cycle toward the VGA adapter interface.
- Adds the following over the previous generation: screen-size and width parameters, per-pixel clipping to the screen, and a filled-disc mode.
- Sits between the top-level sequencer (which muxes it with the screen filler) and the VGA adapter.

Parameters:
- SCREEN_W, 160, visible columns; valid x is 0..SCREEN_W-1.
- SCREEN_H, 120, visible rows; valid y is 0..SCREEN_H-1.
- X_W, 8, width of the x coordinate.
- Y_W, 7, width of the y coordinate.
- R_W, 8, width of the radius.
- COLOUR_W, 3, width of the colour.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to draw; level-sensitive.
- centre_x  input  X_W  circle centre column.
- centre_y  input  Y_W  circle centre row.
- radius  input  R_W  circle radius.
- colour  input  COLOUR_W  pixel colour.
- fill  input  1  0 = outline, 1 = filled disc.
- busy  output  1  high while drawing (INIT through PLOT/STEP).
- done  output  1  drawing complete.
- vga_x  output  X_W  pixel column.
- vga_y  output  Y_W  pixel row.
- vga_colour  output  COLOUR_W  pixel colour.
- vga_plot  output  1  write strobe; vga_x, vga_y and vga_colour are valid when high.

Behaviour:
Reset:
- Asynchronous reset forces state IDLE; busy=0, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
- Reset mid-draw abandons the circle immediately.

States:
- IDLE: when start=1, latch centre_x, centre_y, radius, colour and fill, then go to INIT. Inputs are not re-sampled until the next IDLE.
- INIT (1 cycle): set oy=0, ox=radius, crit=1-radius. crit is signed, R_W+3 bits.
- PLOT: emit pixels of the current (ox, oy) iteration, one per cycle.
  - Outline order, 8 cycles: (cx+ox,cy+oy), (cx+oy,cy+ox), (cx-oy,cy+ox), (cx-ox,cy+oy), (cx-ox,cy-oy), (cx-oy,cy-ox), (cx+oy,cy-ox), (cx+ox,cy-oy).
  - Filled order, four horizontal spans, each left to right, one pixel per cycle:
    - row cy+oy, x = cx-ox..cx+ox
    - row cy-oy, x = cx-ox..cx+ox
    - row cy+ox, x = cx-oy..cx+oy
    - row cy-ox, x = cx-oy..cx+oy
  - Duplicate pixels (e.g. oy=0 or ox=oy) are re-emitted, not suppressed.
- STEP (1 cycle, vga_plot=0):
  - oy += 1.
  - If crit <= 0: crit += 2*oy + 1 (using the new oy).
  - Else: ox -= 1, then crit += 2*(oy-ox) + 1 (using the new ox and oy).
  - If oy <= ox, return to PLOT; otherwise go to DONE.
- DONE: done=1, busy=0. Hold until start=0, then return to IDLE on the next cycle. start held high does not retrigger a draw.

Timing:
- First pixel appears on the cycle after INIT.

Arithmetic and clipping:
- Candidate coordinates are computed signed at X_W+2 / Y_W+2 bits.
- Off-screen pixels (x<0, x>=SCREEN_W, y<0, y>=SCREEN_H) still consume their cycle with vga_plot=0. Cycle count is therefore independent of position.
- vga_x and vga_y carry the truncated value when clipped; they are don't-care there.

Edge cases:
- radius=0: outline emits 8 plots of the centre; filled emits 4 plots of the centre.
- start deasserted mid-draw is ignored; the draw completes.

Optional Feature:
CIRCLE_CLIP_COUNT_EN:
- With the macro defined: adds output port clip_count [15:0].
  - Cleared in INIT.
  - Increments, saturating at 16'hFFFF, on every PLOT cycle whose pixel is clipped.
  - Holds its value through DONE and IDLE; reset value 0.
- Without the macro: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
1. Reset mid-draw: assert rst during PLOT -> busy, done and vga_plot go to 0 asynchronously (without waiting for a clock edge); next start draws normally.
2. Outline, centre (80,60), r=1 -> exactly 16 plot cycles, in order:
   - (81,60) (80,61) (80,61) (79,60) (79,60) (80,59) (80,59) (81,60)
   - (81,61) (81,61) (79,61) (79,61) (79,59) (79,59) (81,59) (81,59)
   - Then done=1 after the final STEP.
3. Outline, r=0 at (10,20) -> 8 plots of (10,20), then done; with start held high, done stays 1 and no new draw begins; start=0 -> IDLE.
4. Filled, centre (10,10), r=1 -> 20 plot cycles covering rows 9..11, x 9..11, except for (9,9), (11,9), (9,11) and (11,11), which are also drawn; all with vga_colour equal to the latched colour.
5. Clipping, centre (0,0), r=5, outline -> no cycle has vga_plot=1 with an off-screen coordinate; total cycle count equals that of centre (80,60), r=5. With CIRCLE_CLIP_COUNT_EN, clip_count equals the number of vga_plot=0 PLOT cycles.
6. Corner, centre (159,119), r=10, fill=1, with SCREEN_W=160 and SCREEN_H=120 -> all plotted pixels satisfy x<=159 and y<=119; colour changed mid-draw has no effect (latched value used).

Source files
------------

// File: rtl/circle_engine_if.sv
// Draw-request and pixel-stream bundle between the sequencer, the circle engine and the VGA adapter.
// master = sequencer side; slave = circle engine side.
interface circle_engine_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int COLOUR_W = 3
);
  logic                start;
  logic [X_W-1:0]      centre_x;
  logic [Y_W-1:0]      centre_y;
  logic [R_W-1:0]      radius;
  logic [COLOUR_W-1:0] colour;
  logic                fill;
  logic                busy;
  logic                done;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  modport master (
    output start, centre_x, centre_y, radius, colour, fill,
    input  busy, done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, centre_x, centre_y, radius, colour, fill,
    output busy, done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/circle_engine.sv
// Midpoint circle / filled-disc drawer streaming one clipped pixel per cycle to the VGA adapter.
// Optional CIRCLE_CLIP_COUNT_EN adds a saturating count of clipped pixel cycles (clip_count).
module circle_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int COLOUR_W = 3
) (
  input logic             clk,
  input logic             rst,
  circle_engine_if.slave  bus
`ifdef CIRCLE_CLIP_COUNT_EN
  ,
  output logic [15:0]     clip_count
`endif
);
  localparam int OW = R_W + 2;
  localparam int CR = R_W + 3;
  localparam int CW = X_W + Y_W + R_W + 4;
  localparam logic signed [X_W+1:0] X_LIM = (X_W+2)'(SCREEN_W);
  localparam logic signed [Y_W+1:0] Y_LIM = (Y_W+2)'(SCREEN_H);

  typedef enum logic [2:0] {IDLE, INIT, PLOT, STEP, DONE} state_t;
  state_t state;

  logic [X_W-1:0]        cx_reg;
  logic [Y_W-1:0]        cy_reg;
  logic [R_W-1:0]        rad_reg;
  logic [COLOUR_W-1:0]   col_reg;
  logic                  fill_reg;
  logic signed [OW-1:0]  ox_reg, oy_reg;
  logic signed [CR-1:0]  crit_reg;
  logic [2:0]            idx_reg;
  logic [OW-1:0]         k_reg;

  // Walk order inside one (ox, oy) iteration: octant index, or span index plus x offset.
  logic signed [OW-1:0]  half;
  logic [OW-1:0]         span_end;
  logic                  span_last, last;
  logic [2:0]            idx_next;
  logic [OW-1:0]         k_next;

  always_comb begin
    half      = idx_reg[1] ? oy_reg : ox_reg;
    span_end  = half << 1;
    span_last = (k_reg == span_end);
    if (fill_reg) begin
      last     = span_last && (idx_reg == 3'd3);
      idx_next = span_last ? idx_reg + 3'd1 : idx_reg;
      k_next   = span_last ? '0 : k_reg + OW'(1);
    end else begin
      last     = (idx_reg == 3'd7);
      idx_next = idx_reg + 3'd1;
      k_next   = '0;
    end
  end

  logic signed [OW-1:0]  oy_step, ox_step;
  logic signed [CR-1:0]  crit_step;

  always_comb begin
    oy_step = oy_reg + OW'(1);
    if (crit_reg[CR-1] || crit_reg == '0) begin
      ox_step   = ox_reg;
      crit_step = crit_reg + (CR'(oy_step) <<< 1) + CR'(1);
    end else begin
      ox_step   = ox_reg - OW'(1);
      crit_step = crit_reg + ((CR'(oy_step) - CR'(ox_step)) <<< 1) + CR'(1);
    end
  end

  // One pixel generator shared by INIT (first pixel), PLOT (next pixel) and STEP (next iteration).
  logic signed [OW-1:0]  a_ox, a_oy;
  logic [2:0]            a_idx;
  logic [OW-1:0]         a_k;

  always_comb begin
    a_ox  = ox_reg;
    a_oy  = oy_reg;
    a_idx = idx_next;
    a_k   = k_next;
    if (state == INIT) begin
      a_ox  = OW'(rad_reg);
      a_oy  = '0;
      a_idx = '0;
      a_k   = '0;
    end else if (state == STEP) begin
      a_ox  = ox_step;
      a_oy  = oy_step;
      a_idx = '0;
      a_k   = '0;
    end
  end

  logic signed [CW-1:0]   ox_w, oy_w, k_w, dx, dy;
  logic signed [X_W+1:0]  x_c;
  logic signed [Y_W+1:0]  y_c;
  logic                   clip;

  always_comb begin
    ox_w = CW'(a_ox);
    oy_w = CW'(a_oy);
    k_w  = CW'(a_k);
    dx   = '0;
    dy   = '0;
    if (fill_reg) begin
      case (a_idx[1:0])
        2'd0:    begin dx = k_w - ox_w; dy =  oy_w; end
        2'd1:    begin dx = k_w - ox_w; dy = -oy_w; end
        2'd2:    begin dx = k_w - oy_w; dy =  ox_w; end
        default: begin dx = k_w - oy_w; dy = -ox_w; end
      endcase
    end else begin
      case (a_idx)
        3'd0:    begin dx =  ox_w; dy =  oy_w; end
        3'd1:    begin dx =  oy_w; dy =  ox_w; end
        3'd2:    begin dx = -oy_w; dy =  ox_w; end
        3'd3:    begin dx = -ox_w; dy =  oy_w; end
        3'd4:    begin dx = -ox_w; dy = -oy_w; end
        3'd5:    begin dx = -oy_w; dy = -ox_w; end
        3'd6:    begin dx =  oy_w; dy = -ox_w; end
        default: begin dx =  ox_w; dy = -oy_w; end
      endcase
    end
    x_c  = (X_W+2)'(CW'(cx_reg) + dx);
    y_c  = (Y_W+2)'(CW'(cy_reg) + dy);
    clip = x_c[X_W+1] || (x_c >= X_LIM) || y_c[Y_W+1] || (y_c >= Y_LIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.vga_plot   <= 1'b0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      cx_reg         <= '0;
      cy_reg         <= '0;
      rad_reg        <= '0;
      col_reg        <= '0;
      fill_reg       <= 1'b0;
      ox_reg         <= '0;
      oy_reg         <= '0;
      crit_reg       <= '0;
      idx_reg        <= '0;
      k_reg          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cx_reg   <= bus.centre_x;
            cy_reg   <= bus.centre_y;
            rad_reg  <= bus.radius;
            col_reg  <= bus.colour;
            fill_reg <= bus.fill;
            bus.busy <= 1'b1;
            state    <= INIT;
          end
        end
        INIT: begin
          ox_reg         <= OW'(rad_reg);
          oy_reg         <= '0;
          crit_reg       <= CR'(1) - CR'(rad_reg);
          idx_reg        <= '0;
          k_reg          <= '0;
          bus.vga_x      <= x_c[X_W-1:0];
          bus.vga_y      <= y_c[Y_W-1:0];
          bus.vga_colour <= col_reg;
          bus.vga_plot   <= !clip;
          state          <= PLOT;
        end
        PLOT: begin
          if (last) begin
            bus.vga_plot <= 1'b0;
            state        <= STEP;
          end else begin
            idx_reg        <= idx_next;
            k_reg          <= k_next;
            bus.vga_x      <= x_c[X_W-1:0];
            bus.vga_y      <= y_c[Y_W-1:0];
            bus.vga_colour <= col_reg;
            bus.vga_plot   <= !clip;
          end
        end
        STEP: begin
          ox_reg   <= ox_step;
          oy_reg   <= oy_step;
          crit_reg <= crit_step;
          idx_reg  <= '0;
          k_reg    <= '0;
          if (oy_step <= ox_step) begin
            bus.vga_x      <= x_c[X_W-1:0];
            bus.vga_y      <= y_c[Y_W-1:0];
            bus.vga_colour <= col_reg;
            bus.vga_plot   <= !clip;
            state          <= PLOT;
          end else begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (!bus.start) begin
            bus.done <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CIRCLE_CLIP_COUNT_EN
  // During PLOT a low strobe means the current pixel is off-screen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_count <= '0;
    end else if (state == INIT) begin
      clip_count <= '0;
    end else if (state == PLOT && !bus.vga_plot && clip_count != 16'hFFFF) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule
